mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-port arbiter that shares the single image-memory port between the filter Controller (port 0) and the image loader/host (port 1). It issues at most one memory command per cycle, with round-robin fairness and optional burst lock, and routes read data back to the port that issued each read. It sits between the requesters and the memory model or BRAM. It drives the same MEMRW/MEMADDR encoding the Controller already uses.

Parameters:
DATA_WIDTH, 24, pixel/data word width
BUS_WIDTH, 32, memory address width
RD_LAT, 1, fixed memory read latency in cycles (1..4)
MAX_BURST, 16, max consecutive locked grants before a forced hand-over

Ports:
Arb_CLK  in  1  clock, rising edge
Arb_RST  in  1  asynchronous reset, active-low
Arb_REQ0/Arb_REQ1  in  1  request from port 0/1
Arb_LOCK0/Arb_LOCK1  in  1  hold ownership for burst
Arb_RW0/Arb_RW1  in  2  01=read, 10=write, 00/11=no-op
Arb_ADDR0/Arb_ADDR1  in  BUS_WIDTH  request address
Arb_WDATA0/Arb_WDATA1  in  DATA_WIDTH  write data
Arb_GNT0/Arb_GNT1  out  1  request accepted this cycle (combinational)
Arb_RVALID0/Arb_RVALID1  out  1  read data valid, 1-cycle pulse
Arb_RDATA0/Arb_RDATA1  out  DATA_WIDTH  returned read data
Arb_MEMRW  out  2  memory command (same encoding as RW)
Arb_MEMADDR  out  BUS_WIDTH  memory address
Arb_MEMWDATA  out  DATA_WIDTH  memory write data
Arb_MEMRDATA  in  DATA_WIDTH  memory read data
Arb_BUSY  out  1  any read outstanding or command issuing

Behaviour:
- Reset (Arb_RST=0, async): MEMRW=00, MEMADDR=0, MEMWDATA=0, RVALIDx=0, RDATAx=0, BUSY=0. FSM goes to IDLE, the round-robin pointer is set so port 0 wins first, the burst counter is 0, and the read-tag pipe is cleared. Reads in flight are dropped, and no RVALID fires for them after reset is released.
- A request is valid when REQx=1 and RWx is 01 or 10. Invalid requests never get GNT.
- Requesters hold REQ/RW/ADDR/WDATA stable until they see GNT=1. A transfer occurs on the rising edge where GNT=1.
- At most one GNT per cycle. GNT is combinational from the current state and the valid requests.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: a single valid requester wins. If both are valid, the port not served last wins.
  - OWNx, arbitration for the next cycle:
    - If LOCKx=1 and REQx is valid, x keeps ownership and the burst count increments.
    - Otherwise the grant follows round-robin.
  - Forced hand-over: when the burst count reaches MAX_BURST and the other port has a valid request, the other port is granted and the count resets to 0.
  - With no valid requests, the FSM returns to IDLE.
  - Any grant to the other port resets the count.
- Command timing: a grant in cycle N drives MEM* outputs (registered) during cycle N+1. With no grant, MEMRW=00 and MEMADDR/MEMWDATA hold their previous values.
- Reads: a tag pipe of depth RD_LAT carries {valid, owner}. MEMRDATA is sampled in cycle N+1+RD_LAT. RDATAx/RVALIDx are registered and valid in cycle N+2+RD_LAT. The owner's RVALID pulses for exactly 1 cycle and the other port's RVALID stays 0.
- RDATAx holds its last value when RVALIDx=0.
- Back-to-back reads from alternating ports return in issue order with no bubbles.
- Writes produce no RVALID.
- BUSY=1 when MEMRW≠00 or any tag valid bit is set.

Test Plan:
- Reset mid-read: port 0 reads addr 0x10, and Arb_RST is pulled low in cycle N+1. Required: all outputs 0 immediately, no RVALID0 after reset is released, BUSY=0.
- Single read, RD_LAT=1: REQ0, RW0=01, ADDR0=0x00000004, with memory returning 0xABCDEF. Required: GNT0 in cycle 0, MEMRW=01 and MEMADDR=4 in cycle 1, RVALID0=1 and RDATA0=0xABCDEF in cycle 3 only.
- Contention: both ports request writes continuously with LOCK=0. Required: grants alternate 0,1,0,1, and MEMWDATA alternates WDATA0/WDATA1.
- Burst lock, MAX_BURST=4: port 1 locked and port 0 requesting. Required: 4 consecutive GNT1, then GNT0, then GNT1 resumes.
- Invalid RW: REQ0=1 with RW0=11 and REQ1 idle. Required: no GNT, MEMRW stays 00, BUSY=0.
- Interleaved reads: port 0 reads A, port 1 reads B, port 0 reads C, back-to-back. Required: RVALID0 (A), RVALID1 (B), RVALID0 (C) on consecutive cycles with correct data.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter with burst lock sharing one image-memory port.
// Ports: Arb_CLK/Arb_RST (async active-low) clock/reset; Arb_REQx/Arb_LOCKx/Arb_RWx/Arb_ADDRx/Arb_WDATAx
// requester side; Arb_GNTx combinational accept; Arb_RVALIDx/Arb_RDATAx read return per port;
// Arb_MEMRW/Arb_MEMADDR/Arb_MEMWDATA registered memory command; Arb_MEMRDATA memory data; Arb_BUSY activity.
module mem_arbiter #(
  parameter int DATA_WIDTH = 24,
  parameter int BUS_WIDTH  = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic                  Arb_CLK,
  input  logic                  Arb_RST,
  input  logic                  Arb_REQ0,
  input  logic                  Arb_REQ1,
  input  logic                  Arb_LOCK0,
  input  logic                  Arb_LOCK1,
  input  logic [1:0]            Arb_RW0,
  input  logic [1:0]            Arb_RW1,
  input  logic [BUS_WIDTH-1:0]  Arb_ADDR0,
  input  logic [BUS_WIDTH-1:0]  Arb_ADDR1,
  input  logic [DATA_WIDTH-1:0] Arb_WDATA0,
  input  logic [DATA_WIDTH-1:0] Arb_WDATA1,
  output logic                  Arb_GNT0,
  output logic                  Arb_GNT1,
  output logic                  Arb_RVALID0,
  output logic                  Arb_RVALID1,
  output logic [DATA_WIDTH-1:0] Arb_RDATA0,
  output logic [DATA_WIDTH-1:0] Arb_RDATA1,
  output logic [1:0]            Arb_MEMRW,
  output logic [BUS_WIDTH-1:0]  Arb_MEMADDR,
  output logic [DATA_WIDTH-1:0] Arb_MEMWDATA,
  input  logic [DATA_WIDTH-1:0] Arb_MEMRDATA,
  output logic                  Arb_BUSY
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam int CW = $clog2(MAX_BURST + 1);
  state_t st_q, st_d;
  logic last_q, last_d, own_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic v0, v1, own1, keep, hand_over, gnt, g1;
  logic [1:0] memrw_q;
  logic [BUS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata0_q, rdata1_q;
  logic [RD_LAT-1:0] tag_v_q, tag_o_q;
  logic rv0_q, rv1_q;
  always_comb begin
    v0 = Arb_REQ0 && (Arb_RW0 == 2'b01 || Arb_RW0 == 2'b10);
    v1 = Arb_REQ1 && (Arb_RW1 == 2'b01 || Arb_RW1 == 2'b10);
    own1 = st_q == OWN1;
    keep = (st_q == OWN0 && Arb_LOCK0 && v0) || (own1 && Arb_LOCK1 && v1);
    // cnt_q counts locked re-grants after the first, so the owner gets MAX_BURST grants in a row
    hand_over = keep && cnt_q >= CW'(MAX_BURST - 1) && (own1 ? v0 : v1);
    gnt = v0 || v1;
    g1 = keep ? own1 ^ hand_over : (v0 && v1 ? ~last_q : v1);
    Arb_GNT0 = gnt && !g1;
    Arb_GNT1 = gnt && g1;
    st_d = !gnt ? IDLE : (g1 ? OWN1 : OWN0);
    last_d = gnt ? g1 : last_q;
    cnt_d = (keep && !hand_over) ? (cnt_q >= CW'(MAX_BURST - 1) ? cnt_q : cnt_q + 1'b1) : '0;
  end
  always_ff @(posedge Arb_CLK or negedge Arb_RST) begin
    if (!Arb_RST) begin
      st_q <= IDLE;
      last_q <= 1'b1;
      cnt_q <= '0;
      own_q <= 1'b0;
      memrw_q <= 2'b00;
      addr_q <= '0;
      wdata_q <= '0;
      tag_v_q <= '0;
      tag_o_q <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      st_q <= st_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      own_q <= g1;
      memrw_q <= gnt ? (g1 ? Arb_RW1 : Arb_RW0) : 2'b00;
      if (gnt) begin
        addr_q <= g1 ? Arb_ADDR1 : Arb_ADDR0;
        wdata_q <= g1 ? Arb_WDATA1 : Arb_WDATA0;
      end
      // tag pipe follows the issued command; MSB is the entry whose data is on MEMRDATA now
      tag_v_q <= RD_LAT'({tag_v_q, memrw_q == 2'b01});
      tag_o_q <= RD_LAT'({tag_o_q, own_q});
      rv0_q <= tag_v_q[RD_LAT-1] && !tag_o_q[RD_LAT-1];
      rv1_q <= tag_v_q[RD_LAT-1] && tag_o_q[RD_LAT-1];
      if (tag_v_q[RD_LAT-1] && !tag_o_q[RD_LAT-1]) rdata0_q <= Arb_MEMRDATA;
      if (tag_v_q[RD_LAT-1] && tag_o_q[RD_LAT-1]) rdata1_q <= Arb_MEMRDATA;
    end
  end
  assign Arb_MEMRW = memrw_q;
  assign Arb_MEMADDR = addr_q;
  assign Arb_MEMWDATA = wdata_q;
  assign Arb_RVALID0 = rv0_q;
  assign Arb_RVALID1 = rv1_q;
  assign Arb_RDATA0 = rdata0_q;
  assign Arb_RDATA1 = rdata1_q;
  assign Arb_BUSY = memrw_q != 2'b00 || |tag_v_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven grant/command vectors plus read and reset sequences for mem_arbiter.
module tb_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
  logic [1:0] rw0 = 0, rw1 = 0;
  logic [31:0] addr0 = 32'h100, addr1 = 32'h200;
  logic [23:0] wd0 = 24'h111111, wd1 = 24'h222222;
  logic gnt0, gnt1, rv0, rv1, busy;
  logic [23:0] rd0, rd1, mwd, mrd = '0;
  logic [1:0] mrw;
  logic [31:0] maddr;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.DATA_WIDTH(24), .BUS_WIDTH(32), .RD_LAT(1), .MAX_BURST(4)) dut (
    .Arb_CLK(clk), .Arb_RST(rst_n),
    .Arb_REQ0(req0), .Arb_REQ1(req1), .Arb_LOCK0(lock0), .Arb_LOCK1(lock1),
    .Arb_RW0(rw0), .Arb_RW1(rw1), .Arb_ADDR0(addr0), .Arb_ADDR1(addr1),
    .Arb_WDATA0(wd0), .Arb_WDATA1(wd1), .Arb_GNT0(gnt0), .Arb_GNT1(gnt1),
    .Arb_RVALID0(rv0), .Arb_RVALID1(rv1), .Arb_RDATA0(rd0), .Arb_RDATA1(rd1),
    .Arb_MEMRW(mrw), .Arb_MEMADDR(maddr), .Arb_MEMWDATA(mwd), .Arb_MEMRDATA(mrd),
    .Arb_BUSY(busy));
  function automatic logic [23:0] memf(input logic [31:0] a);
    return a == 32'h4 ? 24'hABCDEF : a[23:0] ^ 24'h5A5A5A;
  endfunction
  // one-cycle-latency memory: address presented in cycle k, data available in cycle k+1
  always @(posedge clk) mrd <= memf(maddr);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r0, input logic [1:0] w0, input logic l0, input logic [31:0] a0,
                       input logic r1, input logic [1:0] w1, input logic l1, input logic [31:0] a1);
    req0 = r0; rw0 = w0; lock0 = l0; addr0 = a0;
    req1 = r1; rw1 = w1; lock1 = l1; addr1 = a1;
  endtask
  typedef struct {
    logic r0; logic [1:0] w0; logic l0;
    logic r1; logic [1:0] w1; logic l1;
    logic g0; logic g1; logic [1:0] mrw; logic [23:0] mwd;
  } vec_t;
  vec_t tv[16];
  initial begin
    localparam logic [23:0] W0 = 24'h111111, W1 = 24'h222222;
    tv[0]  = '{1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 24'h0};
    tv[1]  = '{1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 24'h0};
    tv[2]  = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 24'h0};
    tv[3]  = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10, W0};
    tv[4]  = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10, W1};
    tv[5]  = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10, W0};
    tv[6]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, W1};
    tv[7]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 2'b00, 24'h0};
    tv[8]  = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 2'b10, W1};
    tv[9]  = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 2'b10, W1};
    tv[10] = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 2'b10, W1};
    tv[11] = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 2'b10, W1};
    tv[12] = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 2'b10, W0};
    tv[13] = '{1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 2'b10, W1};
    tv[14] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, W1};
    tv[15] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 24'h0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memrw", 32'(mrw), 0);
    chk("rst_memaddr", maddr, 0);
    chk("rst_memwdata", 32'(mwd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rvalid", {30'd0, rv1, rv0}, 0);
    chk("rst_rdata", 32'(rd0 | rd1), 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].r0, tv[i].w0, tv[i].l0, 32'h100, tv[i].r1, tv[i].w1, tv[i].l1, 32'h200);
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i), 32'(gnt0), 32'(tv[i].g0));
      chk($sformatf("v%0d_gnt1", i), 32'(gnt1), 32'(tv[i].g1));
      chk($sformatf("v%0d_memrw", i), 32'(mrw), 32'(tv[i].mrw));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].mrw != 2'b00));
      if (tv[i].mrw == 2'b10) chk($sformatf("v%0d_memwdata", i), 32'(mwd), 32'(tv[i].mwd));
      step();
    end
    drive(1, 2'b01, 0, 32'h4, 0, 2'b00, 0, 32'h0);
    @(negedge clk);
    chk("rd_gnt0", {30'd0, gnt1, gnt0}, 32'b01);
    step();
    drive(0, 2'b00, 0, 32'h0, 0, 2'b00, 0, 32'h0);
    @(negedge clk);
    chk("rd_memrw", 32'(mrw), 32'b01);
    chk("rd_memaddr", maddr, 32'h4);
    chk("rd_c1_rvalid", {30'd0, rv1, rv0}, 0);
    step();
    @(negedge clk);
    chk("rd_c2_rvalid", {30'd0, rv1, rv0}, 0);
    chk("rd_c2_busy", 32'(busy), 1);
    step();
    @(negedge clk);
    chk("rd_c3_rvalid", {30'd0, rv1, rv0}, 32'b01);
    chk("rd_c3_rdata0", 32'(rd0), 32'hABCDEF);
    step();
    @(negedge clk);
    chk("rd_c4_rvalid", {30'd0, rv1, rv0}, 0);
    chk("rd_c4_hold", 32'(rd0), 32'hABCDEF);
    chk("rd_c4_busy", 32'(busy), 0);
    step();
    drive(1, 2'b01, 0, 32'h30, 0, 2'b00, 0, 32'h0);
    @(negedge clk);
    chk("il_gnt_a", {30'd0, gnt1, gnt0}, 32'b01);
    step();
    drive(0, 2'b00, 0, 32'h0, 1, 2'b01, 0, 32'h40);
    @(negedge clk);
    chk("il_gnt_b", {30'd0, gnt1, gnt0}, 32'b10);
    step();
    drive(1, 2'b01, 0, 32'h50, 0, 2'b00, 0, 32'h0);
    @(negedge clk);
    chk("il_gnt_c", {30'd0, gnt1, gnt0}, 32'b01);
    step();
    drive(0, 2'b00, 0, 32'h0, 0, 2'b00, 0, 32'h0);
    @(negedge clk);
    chk("il_a_rvalid", {30'd0, rv1, rv0}, 32'b01);
    chk("il_a_rdata0", 32'(rd0), 32'(memf(32'h30)));
    step();
    @(negedge clk);
    chk("il_b_rvalid", {30'd0, rv1, rv0}, 32'b10);
    chk("il_b_rdata1", 32'(rd1), 32'(memf(32'h40)));
    step();
    @(negedge clk);
    chk("il_c_rvalid", {30'd0, rv1, rv0}, 32'b01);
    chk("il_c_rdata0", 32'(rd0), 32'(memf(32'h50)));
    step();
    @(negedge clk);
    chk("il_end_rvalid", {30'd0, rv1, rv0}, 0);
    step();
    drive(1, 2'b01, 0, 32'h10, 0, 2'b00, 0, 32'h0);
    @(negedge clk);
    chk("mr_gnt0", 32'(gnt0), 1);
    step();
    drive(0, 2'b00, 0, 32'h0, 0, 2'b00, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mr_memrw", 32'(mrw), 0);
    chk("mr_memaddr", maddr, 0);
    chk("mr_memwdata", 32'(mwd), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_rvalid", {30'd0, rv1, rv0}, 0);
    chk("mr_rdata", 32'(rd0 | rd1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("mr_post%0d_rvalid0", i), 32'(rv0), 0);
      chk($sformatf("mr_post%0d_busy", i), 32'(busy), 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
